// File: rtl/player_death_controller.sv
// Death/respawn sequencer: one player_died pulse per hit, frozen death
// animation, respawn with blinking invulnerability, sticky game over.
module player_death_controller #(
   parameter int unsigned DEATH_FRAMES  = 60,
   parameter int unsigned INVULN_FRAMES = 90,
   parameter int unsigned BLINK_FRAMES  = 8
) (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic collision,
   input  logic no_lives,
   output logic player_died,
   output logic respawn,
   output logic freeze_player,
   output logic blink_hide,
   output logic game_over
);

   localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
   localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      ALIVE     = 2'd0,
      DYING     = 2'd1,
      INVULN    = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       hit_q, hit_d;
   logic [7:0] frame_q, frame_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       hide_q, hide_d;
   logic       died_q, died_d;
   logic       resp_q, resp_d;
   logic       freeze_q, freeze_d;
   logic       over_q, over_d;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ALIVE;
         hit_q       <= 1'b0;
         frame_q     <= 8'd0;
         blink_cnt_q <= 8'd0;
         hide_q      <= 1'b0;
         died_q      <= 1'b0;
         resp_q      <= 1'b0;
         freeze_q    <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         frame_q     <= frame_d;
         blink_cnt_q <= blink_cnt_d;
         hide_q      <= hide_d;
         died_q      <= died_d;
         resp_q      <= resp_d;
         freeze_q    <= freeze_d;
         over_q      <= over_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hit_d       = hit_q;
      frame_d     = frame_q;
      blink_cnt_d = blink_cnt_q;
      hide_d      = hide_q;
      died_d      = 1'b0;
      resp_d      = 1'b0;
      case (state_q)
         ALIVE: begin
            // the latch spreads pixel-level overlap across the whole frame
            if (startOfFrame && (hit_q || collision)) begin
               state_d = DYING;
               died_d  = 1'b1;
               hit_d   = 1'b0;
               frame_d = 8'd0;
            end else if (collision) begin
               hit_d = 1'b1;
            end
         end
         DYING: begin
            hit_d = 1'b0;
            if (startOfFrame) begin
               if (frame_q == DEATH_LAST) begin
                  if (no_lives) begin
                     state_d = GAME_OVER;
                  end else begin
                     state_d     = INVULN;
                     resp_d      = 1'b1;
                     frame_d     = 8'd0;
                     blink_cnt_d = 8'd0;
                     hide_d      = 1'b0;
                  end
               end else begin
                  frame_d = sat_inc(frame_q);
               end
            end
         end
         INVULN: begin
            hit_d = 1'b0;
            if (startOfFrame) begin
               if (frame_q == INVULN_LAST) begin
                  state_d = ALIVE;
                  hide_d  = 1'b0;
               end else begin
                  frame_d = sat_inc(frame_q);
                  if (blink_cnt_q == BLINK_LAST) begin
                     blink_cnt_d = 8'd0;
                     hide_d      = ~hide_q;
                  end else begin
                     blink_cnt_d = sat_inc(blink_cnt_q);
                  end
               end
            end
         end
         GAME_OVER: begin
            hit_d  = 1'b0;
            hide_d = 1'b0;
         end
         default: begin
            state_d = ALIVE;
            hit_d   = 1'b0;
            hide_d  = 1'b0;
         end
      endcase
      freeze_d = (state_d == DYING) || (state_d == GAME_OVER);
      over_d   = (state_d == GAME_OVER);
   end

   assign player_died   = died_q;
   assign respawn       = resp_q;
   assign freeze_player = freeze_q;
   assign blink_hide    = hide_q;
   assign game_over     = over_q;

endmodule

// File: doc/player_death_controller.md
# player_death_controller

Frame-paced death/respawn sequencer that sits directly upstream of the player life block. It converts raw per-pixel player/monster collision into exactly one `player_died` pulse per hit. It runs a death animation, a respawn request and an invulnerability/blink window. It also consumes `no_lives` from the life block to enter a sticky game-over state.

## Interface
Parameters:
- `DEATH_FRAMES`, default 60: frames the player stays frozen after a hit (1..255).
- `INVULN_FRAMES`, default 90: frames of post-respawn invulnerability (1..255).
- `BLINK_FRAMES`, default 8: frames per blink half-period during invulnerability (1..255).

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `collision`  in  1  player drawing request AND monster drawing request for the current pixel. May be high on many cycles per frame.
- `no_lives`  in  1  from life block; high when remaining lives = 0.
- `player_died`  out  1  one-cycle pulse per accepted hit; drives life block `player_died`.
- `respawn`  out  1  one-cycle pulse; player position block returns the player to start.
- `freeze_player`  out  1  high in DYING and GAME_OVER; movement disabled.
- `blink_hide`  out  1  high when the player sprite must be suppressed (invulnerability blink).
- `game_over`  out  1  sticky game-over flag.

## Operation
States: ALIVE, DYING, INVULN, GAME_OVER. Reset state is ALIVE.
- Internal registers: `hit_latch` (1b), `frame_cnt` (8b), `blink_cnt` (8b).
- ALIVE:
  - `collision`=1 sets `hit_latch`.
  - On a cycle with `startOfFrame`=1 and (`hit_latch` | `collision`): go to DYING, pulse `player_died`, clear `hit_latch`, set `frame_cnt`=0.
  - A hit is therefore accepted at most once per frame, however many pixels overlap.
- DYING:
  - `freeze_player`=1. `collision` is ignored and `hit_latch` is held at 0.
  - Each `startOfFrame` increments `frame_cnt`.
  - On the `startOfFrame` where `frame_cnt` = DEATH_FRAMES-1:
    - if `no_lives`=1, go to GAME_OVER;
    - else pulse `respawn`, go to INVULN, set `frame_cnt`=0, `blink_cnt`=0, `blink_hide`=0.
- INVULN:
  - `collision` is ignored and `hit_latch` is held at 0.
  - Each `startOfFrame` increments `frame_cnt` and `blink_cnt`.
  - When `blink_cnt` reaches BLINK_FRAMES-1, it returns to 0 and `blink_hide` toggles.
  - On the `startOfFrame` where `frame_cnt` = INVULN_FRAMES-1: go to ALIVE, `blink_hide`=0, `hit_latch`=0.
- GAME_OVER:
  - `game_over`=1, `freeze_player`=1, `blink_hide`=0. All inputs are ignored.
  - Exit only by `resetN`.
- Counters saturate at 255. They never wrap within a state, because parameters are at most 255.
- `no_lives` is sampled only at the DYING exit. The life block has by then had at least DEATH_FRAMES frames to register the decrement.

## Timing
- All outputs are registered.
- Reset values: `player_died`=0, `respawn`=0, `freeze_player`=0, `blink_hide`=0, `game_over`=0, state=ALIVE, all counters and `hit_latch`=0.
- Hit latency:
  - `player_died` is high for exactly the one cycle after the clock edge that samples `startOfFrame`.
  - `freeze_player` rises on that same edge.
- DYING lasts exactly DEATH_FRAMES `startOfFrame` pulses. `respawn` (one cycle) and `freeze_player` falling occur on the same edge.
- Blink: `blink_hide` is constant for BLINK_FRAMES frames, then toggles. The first half-period is visible.
- Simultaneous events:
  - A `collision` on the same cycle as `startOfFrame` in ALIVE counts as a hit.
  - A collision in the same cycle as the INVULN→ALIVE transition is ignored.
- Asynchronous reset mid-sequence returns to ALIVE immediately. Any in-flight pulse is truncated.
- No two `player_died` pulses are ever closer than DEATH_FRAMES+INVULN_FRAMES frames.

## Test plan
- Reset, then run 5 frames with no collision: all outputs stay 0 and the state stays ALIVE.
- DEATH_FRAMES=3, INVULN_FRAMES=4, BLINK_FRAMES=2. Assert `collision` for 50 cycles within frame 1:
  - exactly one `player_died` pulse, 1 cycle wide, after the next `startOfFrame`;
  - `freeze_player` high for 3 frames;
  - then one `respawn` pulse;
  - `blink_hide` pattern across the 4 INVULN frames: 0,0,1,1;
  - then ALIVE.
- Same parameters, with `collision` held high continuously through INVULN: no second `player_died` until ALIVE is re-entered. At the first ALIVE `startOfFrame`, a new pulse fires.
- `no_lives` raised during DYING: at DYING exit, `game_over`=1 and `freeze_player`=1, with no `respawn` pulse. Further collisions and frames produce no output change.
- Pull `resetN` low mid-INVULN, with `blink_hide`=1: all outputs are 0 asynchronously. After release, a collision produces a normal `player_died` at the next frame.
- `collision` and `startOfFrame` in the same cycle, with no prior latch: `player_died` fires on the following cycle.
